npc_btb: RTL

Fetch-stage next-PC unit with dynamic branch prediction for the pipelined MIPS CPU. It owns the F-stage PC register and predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It accepts branch/jump resolutions from D and redirects fetch on a mispredict. It generalises the combinational next-PC selector, which always resolves late, with parametrised depth, reset vector and delay-slot handling.

---
 rtl/npc_btb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/npc_btb.sv
// npc_btb: fetch-stage next-PC unit for the pipelined MIPS CPU.
//
// Owns the F-stage PC register and predicts the next fetch address from a
// direct-mapped branch target buffer whose conditional-branch entries carry
// 2-bit saturating counters. Branch/jump resolutions arriving from D train
// the buffer and, on a wrong prediction, redirect fetch at the next edge.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   stall           in   hold pc_F this cycle (a redirect still wins)
//   pc_F            out  current fetch PC (registered)
//   pred_taken_F    out  prediction for the instruction at pc_F
//   pred_target_F   out  predicted target, 0 when not predicted taken
//   res_valid       in   a control-transfer instruction resolved in D
//   res_pc          in   PC of the resolved instruction
//   res_kind        in   00 branch, 01 j/jal, 10 jr/jalr, 11 ignored
//   res_taken       in   actual outcome (implied taken for jumps)
//   res_target      in   actual target
//   res_pred_taken  in   prediction carried down with the instruction
//   res_pred_target in   predicted target carried down with the instruction
//   mispredict      out  combinational; fetch redirected at the next edge
//   mispred_cnt     out  saturating count of mispredicts
module npc_btb #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter int          BTB_DEPTH  = 16,
  parameter logic [1:0]  CTR_INIT   = 2'b01,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] pc_F,
  output logic        pred_taken_F,
  output logic [31:0] pred_target_F,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [1:0]  res_kind,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        mispredict,
  output logic [15:0] mispred_cnt
);

  localparam int          IDX_W    = $clog2(BTB_DEPTH);
  localparam int          TAG_W    = 30 - IDX_W;
  localparam logic [31:0] FALL_OFS = DELAY_SLOT ? 32'd8 : 32'd4;

  logic [BTB_DEPTH-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag    [BTB_DEPTH];
  logic [31:0]          r_target [BTB_DEPTH];
  logic [1:0]           r_kind   [BTB_DEPTH];
  logic [1:0]           r_ctr    [BTB_DEPTH];

  logic [31:0] r_pc;
  logic [15:0] r_misCnt;

  logic [IDX_W-1:0] w_lkIdx;
  logic [TAG_W-1:0] w_lkTag;
  logic             w_lkHit;
  logic [IDX_W-1:0] w_resIdx;
  logic [TAG_W-1:0] w_resTag;
  logic             w_resHit;
  logic             w_effTaken;
  logic             w_update;
  logic [31:0]      w_nextPc;
  logic             w_unused;

  // Word-aligned PCs: the two low address bits never take part in lookup.
  assign w_unused = &{1'b0, pc_F[1:0], res_pc[1:0]};

  assign w_lkIdx  = r_pc[IDX_W+1:2];
  assign w_lkTag  = r_pc[31:IDX_W+2];
  assign w_resIdx = res_pc[IDX_W+1:2];
  assign w_resTag = res_pc[31:IDX_W+2];

  // Zero-latency lookup on the current fetch PC; jumps predict taken on any
  // hit, conditional branches only when the counter's upper bit is set.
  assign w_lkHit       = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
  assign pred_taken_F  = w_lkHit && ((r_kind[w_lkIdx] != 2'b00) || r_ctr[w_lkIdx][1]);
  assign pred_target_F = pred_taken_F ? r_target[w_lkIdx] : 32'd0;
  assign pc_F          = r_pc;

  // Resolution side: jumps are always taken; reserved kind is a no-op.
  assign w_effTaken = res_taken || (res_kind != 2'b00);
  assign w_update   = res_valid && (res_kind != 2'b11);
  assign w_resHit   = r_valid[w_resIdx] && (r_tag[w_resIdx] == w_resTag);
  assign mispredict = w_update &&
                      ((w_effTaken != res_pred_taken) ||
                       (w_effTaken && (res_target != res_pred_target)));

  // A redirect outranks stall so a flushed pipeline never refetches the
  // wrong path; otherwise follow the prediction or fall through.
  always_comb begin
    w_nextPc = r_pc + 32'd4;
    if (mispredict) begin
      w_nextPc = w_effTaken ? res_target : (res_pc + FALL_OFS);
    end else if (stall) begin
      w_nextPc = r_pc;
    end else if (pred_taken_F) begin
      w_nextPc = pred_target_F;
    end
  end

  // PC register and saturating mispredict counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= PC_RESET;
      r_misCnt <= 16'd0;
    end else begin
      r_pc <= w_nextPc;
      if (mispredict && (r_misCnt != 16'hFFFF)) begin
        r_misCnt <= r_misCnt + 16'd1;
      end
    end
  end

  assign mispred_cnt = r_misCnt;

  // Valid bits are the only BTB state that needs clearing: every update,
  // hit or allocation, leaves the addressed entry valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (w_update) begin
      r_valid[w_resIdx] <= 1'b1;
    end
  end

  // Entry payload. Writes land at the edge, so a lookup of the same index in
  // the updating cycle still sees the old contents.
  always_ff @(posedge clk) begin
    if (w_update) begin
      if (w_resHit) begin
        if (res_kind == 2'b00) begin
          if (res_taken) begin
            r_target[w_resIdx] <= res_target;
            if (r_ctr[w_resIdx] != 2'b11) begin
              r_ctr[w_resIdx] <= r_ctr[w_resIdx] + 2'b01;
            end
          end else if (r_ctr[w_resIdx] != 2'b00) begin
            r_ctr[w_resIdx] <= r_ctr[w_resIdx] - 2'b01;
          end
        end else begin
          r_target[w_resIdx] <= res_target;
        end
      end else begin
        r_tag[w_resIdx]    <= w_resTag;
        r_target[w_resIdx] <= res_target;
        r_kind[w_resIdx]   <= res_kind;
        r_ctr[w_resIdx]    <= w_effTaken ? 2'b10 : CTR_INIT;
      end
    end
  end

endmodule
